exp_golomb_enc_pipe: RTL
========================

Name: exp_golomb_enc_pipe

Overview:
- Parametrised, pipelined Exp-Golomb encoder for the CAVLC header and syntax path.
- Successor to the fixed 6-bit combinational delta-QP encoder. Generalises input width, supports ue(v), se(v) and te(v) modes, and adds optional se(v) saturation.
- Sits between the syntax-element sequencer and the bitstream packer. Valid/ready on both sides, two-stage pipeline, one element per cycle sustained.

Parameters:
- VAL_W, 16, input value width: unsigned for ue/te, two's complement for se.
- CLAMP_EN, 0, 1 = saturate se(v) inputs to [SE_MIN, SE_MAX] before mapping.
- SE_MIN, -26, se(v) lower clamp bound, signed VAL_W.
- SE_MAX, 25, se(v) upper clamp bound, signed VAL_W.
- OUT_W, 2*VAL_W+1, codeword width (derived, do not override).
- LEN_W, $clog2(2*VAL_W+2), length field width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  encoder can accept an element this cycle.
- in_mode  in  2  00=ue, 01=se, 10=te, 11=reserved (encoded as ue).
- in_val  in  VAL_W  syntax element value.
- in_te_range  in  1  te(v): 1 = range is exactly 1 (single-bit code), 0 = encode as ue.
- out_valid  out  1  codeword valid.
- out_ready  in  1  packer accepts the codeword.
- out_code  out  OUT_W  codeword, right-aligned, unused MSBs zero.
- out_len  out  LEN_W  number of valid LSBs in out_code, range 1..2*VAL_W+1.
- out_clamped  out  1  se input was saturated (CLAMP_EN=1 only; 0 otherwise).

Behaviour:
- Reset (synchronous, active-high): both stage-valid flags clear. out_valid=0, out_code=0, out_len=0, out_clamped=0. in_ready=1 in the first cycle after reset deasserts. Reset mid-stream drops in-flight elements silently; nothing is flushed.
- Handshakes:
  - Transfer occurs when valid && ready on a side.
  - out_* hold stable while out_valid && !out_ready.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready. Fully combinational back-pressure. No bubble at 100% throughput.
- Stage 1 (registered on input transfer) computes codeNum, width VAL_W+1:
  - ue or reserved mode: codeNum = in_val (zero-extended).
  - se mode: v = clamp(in_val) if CLAMP_EN, else in_val. v>0 gives 2v-1; v<=0 gives -2v. The most-negative input (-2^(VAL_W-1)) gives 2^VAL_W with no overflow.
  - te mode, in_te_range=1: flag single-bit. Codeword is !in_val[0], length 1.
  - te mode, in_te_range=0: same as ue.
  - out_clamped is captured here: 1 iff CLAMP_EN and v differs from in_val.
- Stage 2 (registered when s1 advances):
  - k = codeNum+1, width VAL_W+1, never 0.
  - M = index of the MSB of k (priority encoder), 0..VAL_W.
  - out_len = 2M+1.
  - out_code = k zero-extended to OUT_W. This yields M leading zeros followed by the M+1 bits of k.
  - Single-bit te: out_len=1, out_code={…0, !val[0]}.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 element per cycle.
- Back-pressure: when out_ready=0 with both stages full, in_ready=0 in the same cycle. No element is lost or duplicated.
- Simultaneous events: output transfer and new stage-2 load in the same cycle is legal and keeps out_valid=1.

Test Plan:
- ue, in_val=0 -> after 2 cycles: out_code=1, out_len=1. ue, in_val=3 -> out_code=5'b00100, out_len=5.
- se, in_val=+1 -> code 3'b010, len 3. se, in_val=-2 -> code 5'b00101, len 5. se, in_val=0 -> code 1, len 1.
- CLAMP_EN=1, SE_MIN=-26: se, in_val=-30 -> code 11'b00000110101, len 11, out_clamped=1. se, in_val=25 -> code 11'b00000110010, len 11, out_clamped=0.
- te, range=1: in_val=0 -> code 1, len 1. in_val=1 -> code 0, len 1. te, range=0, in_val=2 -> code 3'b011, len 3.
- VAL_W=16: ue, in_val=16'hFFFF -> out_len=33, out_code=33'h0_0001_0000. se, in_val=16'h8000 -> codeNum 65536, out_len=33, out_code=33'h0_0001_0001.
- Streaming 100 random elements with random out_ready toggling, and rst pulsed mid-stream:
  - Output sequence matches a reference model in order, with no drops or duplicates.
  - out_* stable while stalled.
  - After rst: out_valid=0 next cycle, in_ready=1.

Source files
------------

// File: rtl/exp_golomb_enc_pipe.sv
// exp_golomb_enc_pipe: two-stage pipelined ue/se/te Exp-Golomb encoder with valid/ready on both sides
module exp_golomb_enc_pipe #(
   parameter int VAL_W    = 16,
   parameter bit CLAMP_EN = 0,
   parameter int SE_MIN   = -26,
   parameter int SE_MAX   = 25,
   parameter int OUT_W    = 2*VAL_W+1,
   parameter int LEN_W    = $clog2(2*VAL_W+2)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [VAL_W-1:0] in_val,
   input  logic             in_te_range,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_code,
   output logic [LEN_W-1:0] out_len,
   output logic             out_clamped
);
   localparam logic signed [VAL_W-1:0] SMIN = SE_MIN[VAL_W-1:0];
   localparam logic signed [VAL_W-1:0] SMAX = SE_MAX[VAL_W-1:0];

   logic             s1_valid_q, s1_valid_d, s1_te1_q, s1_te1_d, s1_bit_q, s1_bit_d;
   logic             s1_clamp_q, s1_clamp_d;
   logic [VAL_W:0]   s1_cn_q, s1_cn_d;
   logic             s2_valid_q, s2_valid_d, clamp_q, clamp_d;
   logic [OUT_W-1:0] code_q, code_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             s1_adv, in_fire, s2_load;
   logic signed [VAL_W-1:0] sval, v;
   logic [VAL_W:0]   cn, k;
   logic [LEN_W-1:0] m;

   assign s1_adv      = !s2_valid_q || out_ready;
   assign in_ready    = !s1_valid_q || s1_adv;
   assign in_fire     = in_valid && in_ready;
   assign s2_load     = s1_adv && s1_valid_q;
   assign out_valid   = s2_valid_q;
   assign out_code    = code_q;
   assign out_len     = len_q;
   assign out_clamped = clamp_q;

   // Stage-1 mapping: optional se saturation, then fold signed value onto codeNum (2v-1 / -2v)
   always_comb begin
      sval = $signed(in_val);
      v    = !CLAMP_EN ? sval : (sval < SMIN) ? SMIN : (sval > SMAX) ? SMAX : sval;
      cn   = (in_mode == 2'b01) ? ((!v[VAL_W-1] && |v) ? {v - 1'b1, 1'b1} : {-v, 1'b0}) : {1'b0, in_val};
   end

   // Stage-2 leading-one detect on k = codeNum+1; codeword is k itself, length 2M+1
   always_comb begin
      k = s1_cn_q + 1'b1;
      m = '0;
      for (int i = 0; i <= VAL_W; i++) m = k[i] ? LEN_W'(i) : m;
   end

   // Next state: stage 1 loads on input transfer, stage 2 loads when stage 1 advances, else hold
   always_comb begin
      s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
      s1_cn_d    = in_fire ? cn : s1_cn_q;
      s1_te1_d   = in_fire ? (in_mode == 2'b10 && in_te_range) : s1_te1_q;
      s1_bit_d   = in_fire ? !in_val[0] : s1_bit_q;
      s1_clamp_d = in_fire ? (CLAMP_EN && in_mode == 2'b01 && v != sval) : s1_clamp_q;
      s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
      code_d     = s2_load ? (s1_te1_q ? {{(OUT_W-1){1'b0}}, s1_bit_q} : {{(OUT_W-VAL_W-1){1'b0}}, k}) : code_q;
      len_d      = s2_load ? (s1_te1_q ? LEN_W'(1) : {m[LEN_W-2:0], 1'b1}) : len_q;
      clamp_d    = s2_load ? s1_clamp_q : clamp_q;
   end

   // Pipeline registers; reset drops anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_cn_q    <= '0;
         s1_te1_q   <= 1'b0;
         s1_bit_q   <= 1'b0;
         s1_clamp_q <= 1'b0;
         s2_valid_q <= 1'b0;
         code_q     <= '0;
         len_q      <= '0;
         clamp_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_cn_q    <= s1_cn_d;
         s1_te1_q   <= s1_te1_d;
         s1_bit_q   <= s1_bit_d;
         s1_clamp_q <= s1_clamp_d;
         s2_valid_q <= s2_valid_d;
         code_q     <= code_d;
         len_q      <= len_d;
         clamp_q    <= clamp_d;
      end
   end
endmodule
